// File: rtl/key_line_buffer_ctrl_if.sv
// rtl/key_line_buffer_ctrl_if.sv - keyboard-side and parser-side signals of the key line buffer
// Optional bracket_err member exists only when KEYBUF_BRACKET_CHECK_EN is defined.
interface key_line_buffer_ctrl_if #(
    parameter int AW     = 5,
    parameter int CODE_W = 8
);
    logic [CODE_W-1:0] key_code;
    logic              key_down;
    logic [CODE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;
    logic              line_ready;
    logic [AW:0]       count;
    logic              overflow;
`ifdef KEYBUF_BRACKET_CHECK_EN
    logic              bracket_err;
`endif

    modport master (
        output key_code, key_down, rd_ready,
`ifdef KEYBUF_BRACKET_CHECK_EN
        input  bracket_err,
`endif
        input  rd_data, rd_valid, rd_last, line_ready, count, overflow
    );

    modport slave (
        input  key_code, key_down, rd_ready,
`ifdef KEYBUF_BRACKET_CHECK_EN
        output bracket_err,
`endif
        output rd_data, rd_valid, rd_last, line_ready, count, overflow
    );
endinterface

// File: rtl/key_line_buffer_ctrl.sv
// rtl/key_line_buffer_ctrl.sv - keyboard press-to-line buffer, drains whole lines to the parser
// KEYBUF_BRACKET_CHECK_EN adds a bracket-depth gate on ENTER and the bracket_err pulse.
module key_line_buffer_ctrl #(
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int CODE_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    key_line_buffer_ctrl_if.slave  bus
);
    typedef enum logic {COLLECT, DRAIN} state_t;

    localparam logic [CODE_W-1:0] ENTER_CODE = CODE_W'(3);
    localparam logic [AW:0]       CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]       CNT_TWO    = (AW+1)'(2);
    localparam logic [AW:0]       CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     PTR_ONE    = AW'(1);

    state_t            state;
    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic              key_down_q;
    logic              press;
    logic              is_enter;
    logic              full;
    logic              store;
    logic              drop;
    logic              commit;
    logic              pop;

    assign press      = bus.key_down & ~key_down_q;
    assign is_enter   = (bus.key_code == ENTER_CODE);
    assign full       = (bus.count == CNT_FULL);
    assign store      = (state == COLLECT) && press && !is_enter && !full;
    assign drop       = (state == COLLECT) && press && !is_enter && full;
    assign pop        = (state == DRAIN) && bus.rd_valid && bus.rd_ready;
    assign rd_ptr_nxt = rd_ptr + PTR_ONE;

`ifdef KEYBUF_BRACKET_CHECK_EN
    localparam logic [CODE_W-1:0] OPEN_CODE  = CODE_W'(91);
    localparam logic [CODE_W-1:0] CLOSE_CODE = CODE_W'(93);
    localparam logic signed [AW:0] DEPTH_ONE = (AW+1)'(1);

    logic signed [AW:0] depth;
    logic               reject;

    // Unbalanced lines stay in COLLECT so the user can finish the expression.
    assign commit = (state == COLLECT) && press && is_enter && (bus.count != '0) && (depth == '0);
    assign reject = (state == COLLECT) && press && is_enter && (bus.count != '0) && (depth != '0);
`else
    assign commit = (state == COLLECT) && press && is_enter && (bus.count != '0);
`endif

    always_ff @(posedge clock) begin
        if (store) begin
            mem[wr_ptr] <= bus.key_code;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= COLLECT;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            key_down_q     <= 1'b0;
            bus.count      <= '0;
            bus.overflow   <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.rd_last    <= 1'b0;
            bus.line_ready <= 1'b0;
            bus.rd_data    <= '0;
`ifdef KEYBUF_BRACKET_CHECK_EN
            depth           <= '0;
            bus.bracket_err <= 1'b0;
`endif
        end else begin
            key_down_q <= bus.key_down;
`ifdef KEYBUF_BRACKET_CHECK_EN
            bus.bracket_err <= reject;
            if (store && bus.key_code == OPEN_CODE) begin
                depth <= depth + DEPTH_ONE;
            end else if (store && bus.key_code == CLOSE_CODE) begin
                depth <= depth - DEPTH_ONE;
            end else if (pop && bus.rd_last) begin
                depth <= '0;
            end
`endif
            case (state)
                COLLECT: begin
                    if (store) begin
                        wr_ptr    <= wr_ptr + PTR_ONE;
                        bus.count <= bus.count + CNT_ONE;
                    end
                    if (drop) begin
                        bus.overflow <= 1'b1;
                    end
                    if (commit) begin
                        state          <= DRAIN;
                        bus.line_ready <= 1'b1;
                        bus.rd_valid   <= 1'b1;
                        bus.rd_data    <= mem[rd_ptr];
                        bus.rd_last    <= (bus.count == CNT_ONE);
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        rd_ptr    <= rd_ptr_nxt;
                        bus.count <= bus.count - CNT_ONE;
                        if (bus.rd_last) begin
                            state          <= COLLECT;
                            bus.line_ready <= 1'b0;
                            bus.rd_valid   <= 1'b0;
                            bus.rd_last    <= 1'b0;
                            bus.rd_data    <= '0;
                            bus.overflow   <= 1'b0;
                        end else begin
                            // Prefetch the next byte so it is presented the cycle after the pop.
                            bus.rd_data <= mem[rd_ptr_nxt];
                            bus.rd_last <= (bus.count == CNT_TWO);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
